// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide
// share one 2*WIDTH accumulator; signed ops work on magnitudes and fix signs at the end.
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic                      zero_q;
  logic [1:0]                op_q;
  logic signed [WIDTH-1:0]   a_q;
  logic signed [WIDTH-1:0]   b_q;
  logic                      sign_a;
  logic                      sign_b;
  logic [WIDTH-1:0]          mag_a;
  logic [WIDTH-1:0]          mag_b;
  logic [2*WIDTH-1:0]        acc;

  logic                      is_div;
  logic                      is_signed;
  logic                      b_zero;
  logic [WIDTH:0]            mul_sum;
  logic [2*WIDTH-1:0]        mul_next;
  logic [WIDTH:0]            div_shift;
  logic                      div_ge;
  logic [WIDTH-1:0]          rem_next;
  logic [2*WIDTH-1:0]        div_next;
  logic [2*WIDTH-1:0]        prod_fix;
  logic [WIDTH-1:0]          quo_fix;
  logic [WIDTH-1:0]          rem_fix;

  // Negating in WIDTH+1 bits keeps the most-negative operand's magnitude exact.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    sgn);
    logic signed [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    return (sgn && v[WIDTH-1]) ? WIDTH'(-ext) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign b_zero    = (b_q == '0);

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Accumulator holds {remainder, quotient}; quotient bits enter from the right.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mag_b});
  assign rem_next  = WIDTH'(div_ge ? (div_shift - {1'b0, mag_b}) : div_shift);
  assign div_next  = {rem_next, acc[WIDTH-2:0], div_ge};

  assign prod_fix = neg_2w(acc, sign_a ^ sign_b);
  assign quo_fix  = neg_w(acc[WIDTH-1:0], sign_a ^ sign_b);
  assign rem_fix  = neg_w(acc[2*WIDTH-1:WIDTH], sign_a);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      zero_q   <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= PREP;
              busy  <= 1'b1;
            end
          end
          PREP: begin
            cnt    <= CW'(WIDTH);
            zero_q <= is_div && b_zero;
            state  <= (is_div && b_zero && ZERO_FAST) ? FIX : RUN;
          end
          RUN: begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIX;
          end
          FIX: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (zero_q) begin
              div_zero <= 1'b1;
            end else if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        endcase
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start && !abort) begin
      op_q <= op;
      a_q  <= op_a;
      b_q  <= op_b;
    end
    case (state)
      PREP: begin
        sign_a <= is_signed & a_q[WIDTH-1];
        sign_b <= is_signed & b_q[WIDTH-1];
        mag_a  <= magnitude(a_q, is_signed);
        mag_b  <= magnitude(b_q, is_signed);
        acc    <= {{WIDTH{1'b0}}, is_div ? magnitude(a_q, is_signed) : magnitude(b_q, is_signed)};
      end
      RUN:     acc <= is_div ? div_next : mul_next;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: fast and full-length div-by-zero variants side by side,
// checked every cycle against a latency/arithmetic model plus literal results.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort;
  logic [1:0]   op;
  logic [W-1:0] op_a, op_b;
  logic         busy_f, done_f, dz_f, busy_s, done_s, dz_s;
  logic [W-1:0] hi_f, lo_f, hi_s, lo_s;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  typedef struct packed { logic [W-1:0] h; logic [W-1:0] l; logic z; } res_t;
  typedef struct packed {
    logic busy; logic done; logic dz;
    logic [W-1:0] hi; logic [W-1:0] lo;
    logic [W-1:0] rhi; logic [W-1:0] rlo; logic rz;
    logic [7:0] cnt;
  } mdl_t;

  mdl_t m_f, m_s;

  muldiv_unit #(.WIDTH(W), .ZERO_FAST(1'b1)) u_fast (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .abort(abort),
    .op_a(op_a), .op_b(op_b), .busy(busy_f), .done(done_f), .div_zero(dz_f),
    .hi(hi_f), .lo(lo_f));

  muldiv_unit #(.WIDTH(W), .ZERO_FAST(1'b0)) u_slow (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .abort(abort),
    .op_a(op_a), .op_b(op_b), .busy(busy_s), .done(done_s), .div_zero(dz_s),
    .hi(hi_s), .lo(lo_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t calc(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    longint sa, sb, q, rm;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (o)
      MULT: begin
        p = 64'(sa * sb);
        r.h = p[2*W-1:W]; r.l = p[W-1:0];
      end
      MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        r.h = p[2*W-1:W]; r.l = p[W-1:0];
      end
      DIV: begin
        if (b == '0) r.z = 1'b1;
        else begin
          q = sa / sb; rm = sa % sb;
          r.l = q[W-1:0]; r.h = rm[W-1:0];
        end
      end
      default: begin
        if (b == '0) r.z = 1'b1;
        else begin r.l = a / b; r.h = a % b; end
      end
    endcase
    return r;
  endfunction

  // One clock of the reference: results appear a fixed latency after acceptance.
  function automatic mdl_t step(input mdl_t m, input bit zf, input logic st, input logic ab,
                                input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    mdl_t n;
    res_t r;
    n = m;
    n.done = 1'b0;
    n.dz = 1'b0;
    if (m.busy) begin
      if (ab) n.busy = 1'b0;
      else if (m.cnt == 8'd1) begin
        n.busy = 1'b0; n.done = 1'b1;
        if (m.rz) n.dz = 1'b1;
        else begin n.hi = m.rhi; n.lo = m.rlo; end
      end else n.cnt = m.cnt - 8'd1;
    end else if (st && !ab) begin
      r = calc(o, a, b);
      n.busy = 1'b1; n.rhi = r.h; n.rlo = r.l; n.rz = r.z;
      n.cnt = (zf && r.z) ? 8'd2 : 8'(W + 2);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_f <= '0;
    else m_f <= step(m_f, 1'b1, start, abort, op, op_a, op_b);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_s <= '0;
    else m_s <= step(m_s, 1'b0, start, abort, op, op_a, op_b);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string nm, input mdl_t m, input logic b, input logic d,
                     input logic z, input logic [W-1:0] h, input logic [W-1:0] l);
    chk({nm, " busy"}, 64'(b), 64'(m.busy));
    chk({nm, " done"}, 64'(d), 64'(m.done));
    chk({nm, " div_zero"}, 64'(z), 64'(m.dz));
    chk({nm, " hi"}, 64'(h), 64'(m.hi));
    chk({nm, " lo"}, 64'(l), 64'(m.lo));
  endtask

  always @(negedge clk) begin
    cmp("cyc_fast", m_f, busy_f, done_f, dz_f, hi_f, lo_f);
    cmp("cyc_slow", m_s, busy_s, done_s, dz_s, hi_s, lo_s);
  end

  task automatic chk_hilo(input string nm, input logic [W-1:0] eh, input logic [W-1:0] el);
    chk({nm, " hi_f"}, 64'(hi_f), 64'(eh));
    chk({nm, " lo_f"}, 64'(lo_f), 64'(el));
    chk({nm, " hi_s"}, 64'(hi_s), 64'(eh));
    chk({nm, " lo_s"}, 64'(lo_s), 64'(el));
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input bit ez, input bit poke);
    int e0, lat_f, lat_s;
    logic z_f, z_s;
    lat_f = -1; lat_s = -1; z_f = 1'b0; z_s = 1'b0;
    @(negedge clk);
    op = o; op_a = a; op_b = b; start = 1'b1; e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && (lat_f < 0 || lat_s < 0); i++) begin
      if (done_f && lat_f < 0) begin lat_f = cyc - e0; z_f = dz_f; end
      if (done_s && lat_s < 0) begin lat_s = cyc - e0; z_s = dz_s; end
      if (poke && cyc == e0 + 4) begin
        start = 1'b1; op = MULT; op_a = 32'h0000DEAD; op_b = 32'd3;
      end else start = 1'b0;
      if (lat_f < 0 || lat_s < 0) @(negedge clk);
    end
    start = 1'b0;
    chk({nm, " latency_f"}, 64'(lat_f), ez ? 64'd2 : 64'(W + 2));
    chk({nm, " latency_s"}, 64'(lat_s), 64'(W + 2));
    chk({nm, " div_zero_f"}, 64'(z_f), 64'(ez));
    chk({nm, " div_zero_s"}, 64'(z_s), 64'(ez));
    chk_hilo(nm, eh, el);
  endtask

  task automatic count_done(input string nm, input int n);
    int nd;
    nd = 0;
    repeat (n) begin
      @(negedge clk);
      if (done_f || done_s) nd++;
    end
    chk({nm, " no_done"}, 64'(nd), 64'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=20000", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    int e0;
    res_t r;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op = MULT; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", 64'(busy_f | busy_s), 64'd0);
    chk("reset done", 64'(done_f | done_s), 64'd0);
    chk("reset div_zero", 64'(dz_f | dz_s), 64'd0);
    chk_hilo("reset", 32'h0, 32'h0);

    r = calc(MULT, 32'hFFFFFFFD, 32'd5);
    chk("model mult", {r.h, r.l}, 64'hFFFFFFFF_FFFFFFF1);
    r = calc(DIV, 32'hFFFFFFF9, 32'd2);
    chk("model div", {r.h, r.l}, 64'hFFFFFFFF_FFFFFFFD);

    run_op("mult_neg",   MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    run_op("multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    run_op("mult_minsq", MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    run_op("div_neg",    DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu_poke",  DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 1'b1);
    run_op("div_wrap",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    run_op("div_negdiv", DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu_prior", DIVU,  32'd59,       32'd6,        32'd5,        32'd9,        1'b0, 1'b0);
    run_op("divu_zero",  DIVU,  32'd100,      32'd0,        32'd5,        32'd9,        1'b1, 1'b0);

    // Abort mid-run, with an ignored start in between.
    @(negedge clk);
    op = MULT; op_a = 32'd6; op_b = 32'd7; start = 1'b1; e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 4) @(negedge clk);
    op = DIVU; op_a = 32'd99; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", 64'(busy_f | busy_s), 64'd0);
    count_done("abort", 40);
    chk_hilo("abort", 32'd5, 32'd9);

    // Abort and start together while idle: request dropped.
    op = MULT; op_a = 32'd1; op_b = 32'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort busy", 64'(busy_f | busy_s), 64'd0);
    count_done("idle_abort", 40);

    run_op("mult_again", MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

    // Abort in the final cycle beats the result write.
    @(negedge clk);
    op = MULT; op_a = 32'd2; op_b = 32'd3; start = 1'b1; e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + W + 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("fix_abort busy", 64'(busy_f | busy_s), 64'd0);
    count_done("fix_abort", 5);
    chk_hilo("fix_abort", 32'd0, 32'd42);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    op = DIV; op_a = 32'd100; op_b = 32'd7; start = 1'b1; e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e0 + 19) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst busy", 64'(busy_f | busy_s), 64'd0);
    chk_hilo("async_rst", 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_after_rst", DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
